bus_arbiter8: RTL and testbench
===============================

// Module: bus_arbiter8
// PURPOSE
//  Round-robin arbiter sharing one 8-source bus between 8 requesters.
//  Drives the one-hot grant back to the requesters and the 3-bit select of the
//  8:1 bus mux, so only the granted source reaches the shared line.
//  Inserts one dead (handover) cycle between owners to avoid contention.
// PARAMETERS
//  MAX_HOLD  16  max consecutive GRANT cycles before forced release (ARB_TIMEOUT_EN only)
//  CNT_W      5  hold counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk       in   1  single clock, all logic on rising edge
//  rst       in   1  synchronous, active-high reset
//  req       in   8  request per source; held high for the whole bus tenure
//  gnt       out  8  one-hot registered grant; 0 when bus is free
//  sel       out  3  mux select = index of current/last owner
//  bus_busy  out  1  registered, equals |gnt
//  timeout   out  1  one-cycle pulse on forced release (0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, gnt=0, sel=0, bus_busy=0, timeout=0,
//   ptr=7, hold_cnt=0. Takes effect at the next edge even mid-tenure.
//  States: IDLE, GRANT, HANDOVER.
//  Arbitration (in IDLE and HANDOVER): winner = first set req bit scanning
//   ptr+1, ptr+2, ... ptr+8 mod 8 (ptr itself is last, so the previous
//   owner has lowest priority but is re-granted if it is the only requester).
//  IDLE: req==0 -> stay. Else at that edge: gnt<=1<<winner, sel<=winner,
//   ptr<=winner, bus_busy<=1, hold_cnt<=0, -> GRANT. Latency req->gnt = 1 clk.
//  GRANT: req[sel]==1 -> hold, hold_cnt increments (saturates at MAX_HOLD).
//   req[sel]==0 at edge -> gnt<=0, bus_busy<=0, -> HANDOVER.
//  HANDOVER: exactly one cycle with gnt=0. If req!=0 arbitrate and -> GRANT
//   at its closing edge; else -> IDLE. Owner-to-owner gap is one clock.
//  sel holds the last owner while idle/handover; never changes during GRANT.
//  Non-owner req changes during GRANT are ignored until next arbitration.
//  gnt is always one-hot or zero; never two bits set, never set in HANDOVER.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: in GRANT, if hold_cnt==MAX_HOLD-1 and the owner
//   still requests and any other req bit is set, force release at that edge:
//   gnt<=0, timeout<=1 for one cycle, -> HANDOVER; owner's ptr makes it lowest
//   priority. If no other requester, no release; hold_cnt saturates.
//  ARB_TIMEOUT_EN undefined: no hold counter, tenure unbounded, timeout tied 0.
// TESTING
//  1 rst 2 clk, then req=8'h01 -> next clk gnt=8'h01, sel=0, bus_busy=1.
//  2 req=8'hFF, each owner drops req after 2 GRANT cycles -> grant order
//    0,1,...,7,0 with exactly one gnt=0 cycle between owners.
//  3 owner 3 releases with req=8'h0C pending -> after handover gnt=8'h04, sel=2.
//  4 ARB_TIMEOUT_EN, MAX_HOLD=4: req0 held, req5 set at grant -> after 4 GRANT
//    cycles gnt=0 + timeout=1 (1 clk), next clk gnt=8'h20; req0 alone never revoked.
//  5 rst while gnt=8'h10 -> next clk gnt=0, bus_busy=0; then req=8'h11 ->
//    gnt=8'h01 (ptr reset to 7).
//  6 req=8'h40 only, pulsed low 1 clk during GRANT -> HANDOVER then gnt=8'h40 again.

Source files
------------

// File: rtl/bus_arbiter8.sv
// bus_arbiter8 -- round-robin arbiter for one bus shared by 8 sources.
//
// Grants the bus to one requester at a time. A one-cycle handover with no
// grant is inserted between owners so two sources never drive the shared
// line together. The most recent owner has the lowest priority at the next
// arbitration.
//
// Ports
//   clk       in   1  clock, everything on the rising edge
//   rst       in   1  synchronous active-high reset
//   req       in   8  per-source request, held high for the whole tenure
//   gnt       out  8  registered one-hot grant, 0 when the bus is free
//   sel       out  3  8:1 bus mux select = current or last owner
//   bus_busy  out  1  registered, equals |gnt
//   timeout   out  1  one-cycle pulse on a forced release
//
// Handshake: a source owns the bus on every cycle where its gnt bit is 1.
// It keeps req high for as long as it wants the bus. When req drops (or the
// tenure is forced to end), gnt drops at the next edge. Nothing else is
// exchanged.
//
// Build option ARB_TIMEOUT_EN: when defined, an owner that has held the bus
// for MAX_HOLD grant cycles while another source is waiting is forced off
// and timeout pulses. When undefined, tenure is unbounded and timeout is 0.
module bus_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       bus_busy,
  output logic       timeout
);

  // The hold counter must be able to reach MAX_HOLD.
  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("bus_arbiter8: CNT_W too small for MAX_HOLD");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    HANDOVER = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [7:0] gnt_n;
  logic [2:0] sel_n;
  logic [2:0] ptr, ptr_n;
  logic       busy_n;
  logic [2:0] winner;

  // Scan ptr+1 .. ptr+8 (mod 8). Iterating from the farthest offset down
  // leaves the nearest requester as the final assignment, so the previous
  // owner (offset 8 == ptr) only wins when it is the sole requester.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    pick = p;
    for (int i = 8; i >= 1; i--) begin
      idx = p + 3'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign winner = pick(req, ptr);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic             timeout_q, timeout_n;
  logic             others_waiting;

  assign others_waiting = |(req & ~(8'b1 << sel));
  assign timeout        = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    ptr_n   = ptr;
    busy_n  = bus_busy;
`ifdef ARB_TIMEOUT_EN
    hold_n    = hold_cnt;
    timeout_n = 1'b0;
`endif
    case (state)
      IDLE, HANDOVER: begin
        if (req != 8'h00) begin
          gnt_n   = 8'b1 << winner;
          sel_n   = winner;
          ptr_n   = winner;
          busy_n  = 1'b1;
          state_n = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_n  = '0;
`endif
        end else begin
          gnt_n   = 8'h00;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          gnt_n   = 8'h00;
          busy_n  = 1'b0;
          state_n = HANDOVER;
        end
`ifdef ARB_TIMEOUT_EN
        // ptr already points at the owner, so it is last in line next time.
        else if (hold_cnt == CNT_W'(MAX_HOLD - 1) && others_waiting) begin
          gnt_n     = 8'h00;
          busy_n    = 1'b0;
          timeout_n = 1'b1;
          state_n   = HANDOVER;
        end else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
          hold_n = hold_cnt + 1'b1;
        end
`endif
      end
      default: begin
        gnt_n   = 8'h00;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 8'h00;
      sel      <= 3'd0;
      ptr      <= 3'd7;
      bus_busy <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      bus_busy <= busy_n;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= hold_n;
      timeout_q <= timeout_n;
`endif
    end
  end

endmodule

// File: tb/tb_bus_arbiter8.sv
// tb_bus_arbiter8 -- directed bench for bus_arbiter8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they show the result of the edge just taken.
module tb_bus_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       bus_busy;
  logic       timeout;

  int checks;
  int errors;

  bus_arbiter8 #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    do_reset();
    checks++;
    if (gnt !== 8'h00 || sel !== 3'd0 || bus_busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: gnt=%h sel=%0d busy=%b to=%b, want 00 0 0 0",
               gnt, sel, bus_busy, timeout);
    end
    req = 8'h01;
    step();
    checks++;
    if (gnt !== 8'h01 || sel !== 3'd0 || bus_busy !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: gnt=%h sel=%0d busy=%b, want 01 0 1", gnt, sel, bus_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_g;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'b1 << (k % 8);
      step();
      checks++;
      if (gnt !== exp_g || sel !== 3'(k % 8) || bus_busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant k=%0d: gnt=%h sel=%0d busy=%b, want %h %0d 1",
                 k, gnt, sel, bus_busy, exp_g, k % 8);
      end
      step();
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL rr_hold k=%0d: gnt=%h, want %h", k, gnt, exp_g);
      end
      req = 8'hFF & ~exp_g;
      step();
      checks++;
      if (gnt !== 8'h00 || bus_busy !== 1'b0 || sel !== 3'(k % 8)) begin
        errors++;
        $display("FAIL rr_handover k=%0d: gnt=%h busy=%b sel=%0d, want 00 0 %0d",
                 k, gnt, bus_busy, sel, k % 8);
      end
      req = 8'hFF;
    end
    req = 8'h00;
    step();
    step();
    checks++;
    if (gnt !== 8'h00 || bus_busy !== 1'b0 || sel !== 3'd0) begin
      errors++;
      $display("FAIL rr_idle: gnt=%h busy=%b sel=%0d, want 00 0 0", gnt, bus_busy, sel);
    end
  endtask

  task automatic test_pending_release();
    do_reset();
    req = 8'h08;
    step();
    req = 8'h0C;
    step();
    checks++;
    if (gnt !== 8'h08 || sel !== 3'd3) begin
      errors++;
      $display("FAIL pend_hold: gnt=%h sel=%0d, want 08 3", gnt, sel);
    end
    req = 8'h04;
    step();
    checks++;
    if (gnt !== 8'h00 || sel !== 3'd3) begin
      errors++;
      $display("FAIL pend_handover: gnt=%h sel=%0d, want 00 3", gnt, sel);
    end
    step();
    checks++;
    if (gnt !== 8'h04 || sel !== 3'd2 || bus_busy !== 1'b1) begin
      errors++;
      $display("FAIL pend_next: gnt=%h sel=%0d busy=%b, want 04 2 1", gnt, sel, bus_busy);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h21;
    step();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (gnt !== 8'h01 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_hold c=%0d: gnt=%h to=%b, want 01 0", c, gnt, timeout);
      end
      step();
    end
`ifdef ARB_TIMEOUT_EN
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b1 || bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL to_release: gnt=%h to=%b busy=%b, want 00 1 0", gnt, timeout, bus_busy);
    end
    step();
    checks++;
    if (gnt !== 8'h20 || sel !== 3'd5 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_next: gnt=%h sel=%0d to=%b, want 20 5 0", gnt, sel, timeout);
    end
`else
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (gnt !== 8'h01 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL no_timeout c=%0d: gnt=%h to=%b, want 01 0", c, gnt, timeout);
      end
      step();
    end
`endif
    // A lone requester is never revoked.
    do_reset();
    req = 8'h01;
    for (int c = 0; c < 12; c++) begin
      step();
      checks++;
      if (gnt !== 8'h01 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL alone c=%0d: gnt=%h to=%b, want 01 0", c, gnt, timeout);
      end
    end
  endtask

  task automatic test_reset_mid_tenure();
    do_reset();
    req = 8'h10;
    step();
    checks++;
    if (gnt !== 8'h10 || sel !== 3'd4) begin
      errors++;
      $display("FAIL mid_pre: gnt=%h sel=%0d, want 10 4", gnt, sel);
    end
    rst = 1'b1;
    step();
    checks++;
    if (gnt !== 8'h00 || bus_busy !== 1'b0 || sel !== 3'd0) begin
      errors++;
      $display("FAIL mid_rst: gnt=%h busy=%b sel=%0d, want 00 0 0", gnt, bus_busy, sel);
    end
    rst = 1'b0;
    req = 8'h11;
    step();
    checks++;
    if (gnt !== 8'h01 || sel !== 3'd0) begin
      errors++;
      $display("FAIL mid_after: gnt=%h sel=%0d, want 01 0", gnt, sel);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 8'h40;
    step();
    checks++;
    if (gnt !== 8'h40 || sel !== 3'd6) begin
      errors++;
      $display("FAIL b2b_first: gnt=%h sel=%0d, want 40 6", gnt, sel);
    end
    req = 8'h00;
    step();
    checks++;
    if (gnt !== 8'h00 || bus_busy !== 1'b0 || sel !== 3'd6) begin
      errors++;
      $display("FAIL b2b_gap: gnt=%h busy=%b sel=%0d, want 00 0 6", gnt, bus_busy, sel);
    end
    req = 8'h40;
    step();
    checks++;
    if (gnt !== 8'h40 || bus_busy !== 1'b1 || sel !== 3'd6) begin
      errors++;
      $display("FAIL b2b_regrant: gnt=%h busy=%b sel=%0d, want 40 1 6", gnt, bus_busy, sel);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = 8'h00;
    test_reset();
    test_round_robin();
    test_pending_release();
    test_timeout();
    test_reset_mid_tenure();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
